// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter: command encodings
// (also used by the CPU state controller), FSM states and owner identities.
package mem_arbiter_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MNONE  = 2'b00;
  localparam mem_cmd_t MREAD  = 2'b01;
  localparam mem_cmd_t MWRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // 2'b11 is an unused encoding and counts as no request.
  function automatic logic cmd_active(input mem_cmd_t cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU port, the DMA port and the single-port RAM.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  mem_cmd_t            cpu_cmd;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic                cpu_stall;
  logic                cpu_rvalid;
  logic [DATA_W-1:0]   cpu_rdata;

  logic                dma_req;
  logic                dma_we;
  logic [ADDR_W-1:0]   dma_addr;
  logic [DATA_W-1:0]   dma_wdata;
  logic                dma_gnt;
  logic                dma_rvalid;
  logic [DATA_W-1:0]   dma_rdata;

  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  modport slave (
    input  cpu_cmd, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output cpu_cmd, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for one single-port RAM. The CPU is never preempted; DMA
// bursts are capped at BURST_MAX beats whenever the CPU is waiting. Reads
// return one cycle after grant and are steered back by a registered tag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_e            state;
  state_e            state_nxt;
  owner_e            owner_now;
  owner_e            last_owner;
  owner_e            rd_tag;
  logic [3:0]        beat_cnt;
  logic [3:0]        beat_cnt_nxt;
  logic              rd_pend;
  logic              rd_pend_nxt;
  logic              cpu_req;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  assign cpu_req = cmd_active(bus.cpu_cmd);

  // Owner of the RAM this cycle; nobody owns it while reset is held.
  always_comb begin
    owner_now = OWN_NONE;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (cpu_req && bus.dma_req)
            owner_now = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
          else if (cpu_req)
            owner_now = OWN_CPU;
          else if (bus.dma_req)
            owner_now = OWN_DMA;
        end
        S_CPU: begin
          if (cpu_req)
            owner_now = OWN_CPU;
          else if (bus.dma_req)
            owner_now = OWN_DMA;
        end
        S_DMA: begin
          if (bus.dma_req) begin
            if (beat_cnt < BURST_LIM)
              owner_now = OWN_DMA;
            else if (cpu_req)
              owner_now = OWN_CPU;
            else
              owner_now = OWN_DMA;
          end else if (cpu_req) begin
            owner_now = OWN_CPU;
          end
        end
        default: owner_now = OWN_NONE;
      endcase
    end
  end

  // Next state, burst count and read-pending flag follow the chosen owner.
  always_comb begin
    state_nxt    = S_IDLE;
    beat_cnt_nxt = 4'd0;
    rd_pend_nxt  = 1'b0;
    case (owner_now)
      OWN_CPU: begin
        state_nxt   = S_CPU;
        rd_pend_nxt = (bus.cpu_cmd == MREAD);
      end
      OWN_DMA: begin
        state_nxt    = S_DMA;
        beat_cnt_nxt = (beat_cnt == BURST_LIM) ? 4'd1 : beat_cnt + 4'd1;
        rd_pend_nxt  = !bus.dma_we;
      end
      default: ;
    endcase
  end

  // RAM port mux driven by the current owner, zero when idle.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    case (owner_now)
      OWN_CPU: begin
        addr_mux  = bus.cpu_addr;
        wdata_mux = bus.cpu_wdata;
        we_mux    = (bus.cpu_cmd == MWRITE);
      end
      OWN_DMA: begin
        addr_mux  = bus.dma_addr;
        wdata_mux = bus.dma_wdata;
        we_mux    = bus.dma_we;
      end
      default: ;
    endcase
  end

  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;
  assign bus.ram_we     = we_mux;
  assign bus.dma_gnt    = (owner_now == OWN_DMA);
  assign bus.cpu_stall  = !rst && cpu_req && (owner_now != OWN_CPU);
  assign bus.cpu_rvalid = !rst && rd_pend && (rd_tag == OWN_CPU);
  assign bus.dma_rvalid = !rst && rd_pend && (rd_tag == OWN_DMA);
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = bus.ram_rdata;

  // Control state: reset drops any read in flight and biases the first tie to the CPU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_owner <= OWN_DMA;
      beat_cnt   <= 4'd0;
      rd_pend    <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      rd_pend  <= rd_pend_nxt;
      if (owner_now != OWN_NONE)
        last_owner <= owner_now;
    end
  end

  // Read tag captured at grant so a same-cycle ownership change cannot misroute the return.
  always_ff @(posedge clk) begin
    rd_tag <= owner_now;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for ties, bursts, tagged returns and reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM: write at the edge, read data one cycle after the address.
  logic [15:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input mem_cmd_t cmd, input logic [7:0] ca,
                       input logic [15:0] cw, input logic dq, input logic dw,
                       input logic [7:0] da, input logic [15:0] dd);
    rst           = r;
    bus.cpu_cmd   = cmd;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cw;
    bus.dma_req   = dq;
    bus.dma_we    = dw;
    bus.dma_addr  = da;
    bus.dma_wdata = dd;
  endtask

  typedef struct {
    logic        rst;
    mem_cmd_t    cmd;
    logic [7:0]  caddr;
    logic [15:0] cwdata;
    logic        dreq;
    logic        dwe;
    logic [7:0]  daddr;
    logic [15:0] dwdata;
    logic        stall;
    logic        gnt;
    logic        we;
    logic [7:0]  raddr;
    logic [15:0] rwdata;
    logic        crv;
    logic        drv;
    logic [15:0] rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  mem_cmd_t c_cmd   [8];
  logic     c_gnt   [8];
  logic     c_stall [8];
  logic     c_crv   [8];
  logic     c_dreq  [8];

  initial begin
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 16'h0000;
    drive(1'b1, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    //            rst   cmd     caddr  cwdata    dreq  dwe   daddr  dwdata    stall gnt   we    raddr  rwdata    crv   drv   rdata
    tbl[0]  = '{1'b1, MREAD,  8'h10, 16'h0C0C, 1'b1, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, MNONE,  8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, MREAD,  8'h10, 16'h0C0C, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0C0C, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, MREAD,  8'h10, 16'h0C0C, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0C0C, 1'b1, 1'b0, 16'hBEEF};
    tbl[4]  = '{1'b0, MNONE,  8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    tbl[5]  = '{1'b0, 2'b11,  8'h44, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, MWRITE, 8'h30, 16'hA5A5, 1'b1, 1'b1, 8'h31, 16'h1111, 1'b1, 1'b1, 1'b1, 8'h31, 16'h1111, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, MWRITE, 8'h30, 16'hA5A5, 1'b1, 1'b1, 8'h32, 16'h2222, 1'b1, 1'b1, 1'b1, 8'h32, 16'h2222, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, MWRITE, 8'h30, 16'hA5A5, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h30, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{1'b0, MREAD,  8'h31, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h31, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, MREAD,  8'h30, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b0, 16'h1111};
    tbl[11] = '{1'b0, MNONE,  8'h00, 16'h0000, 1'b1, 1'b0, 8'h32, 16'h7777, 1'b0, 1'b1, 1'b0, 8'h32, 16'h7777, 1'b1, 1'b0, 16'hA5A5};
    tbl[12] = '{1'b0, MNONE,  8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h2222};
    tbl[13] = '{1'b0, MNONE,  8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000};

    // RAM preload while the arbiter sits in reset.
    @(negedge clk); pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF;
    @(negedge clk); pl_en = 1'b1; pl_addr = 8'h20; pl_data = 16'h1234;
    @(negedge clk); pl_en = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].cmd, tbl[i].caddr, tbl[i].cwdata,
            tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].dwdata);
      #1;
      chk($sformatf("v%0d.cpu_stall", i),  32'(bus.cpu_stall),  32'(tbl[i].stall));
      chk($sformatf("v%0d.dma_gnt", i),    32'(bus.dma_gnt),    32'(tbl[i].gnt));
      chk($sformatf("v%0d.ram_we", i),     32'(bus.ram_we),     32'(tbl[i].we));
      chk($sformatf("v%0d.ram_addr", i),   32'(bus.ram_addr),   32'(tbl[i].raddr));
      chk($sformatf("v%0d.ram_wdata", i),  32'(bus.ram_wdata),  32'(tbl[i].rwdata));
      chk($sformatf("v%0d.cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(tbl[i].crv));
      chk($sformatf("v%0d.dma_rvalid", i), 32'(bus.dma_rvalid), 32'(tbl[i].drv));
      if (tbl[i].crv) chk($sformatf("v%0d.cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tbl[i].rdata));
      if (tbl[i].drv) chk($sformatf("v%0d.dma_rdata", i), 32'(bus.dma_rdata), 32'(tbl[i].rdata));
    end

    // Tie right after reset: CPU first, DMA granted the cycle the CPU goes idle.
    @(negedge clk); drive(1'b1, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk); drive(1'b1, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk); drive(1'b0, MREAD, 8'h10, 16'h0000, 1'b1, 1'b1, 8'h40, 16'h0404);
    #1;
    chk("tie.a0.dma_gnt",   32'(bus.dma_gnt),   32'd0);
    chk("tie.a0.cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("tie.a0.ram_addr",  32'(bus.ram_addr),  32'h10);
    @(negedge clk); #1;
    chk("tie.a1.dma_gnt",    32'(bus.dma_gnt),    32'd0);
    chk("tie.a1.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("tie.a1.cpu_rdata",  32'(bus.cpu_rdata),  32'hBEEF);
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'h0404);
    #1;
    chk("tie.a2.dma_gnt",   32'(bus.dma_gnt),   32'd1);
    chk("tie.a2.ram_addr",  32'(bus.ram_addr),  32'h40);
    chk("tie.a2.ram_we",    32'(bus.ram_we),    32'd1);
    chk("tie.a2.ram_wdata", 32'(bus.ram_wdata), 32'h0404);
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("tie.a3.dma_gnt", 32'(bus.dma_gnt), 32'd0);

    // Ten back-to-back DMA writes with the CPU idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b1, 1'b1, 8'(8'h50 + i), 16'(16'hD000 + i));
      #1;
      chk($sformatf("burst10.b%0d.dma_gnt", i), 32'(bus.dma_gnt), 32'd1);
    end
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("burst10.end.dma_gnt", 32'(bus.dma_gnt), 32'd0);
    for (int i = 0; i < 10; i++)
      chk($sformatf("burst10.ram%0d", i), 32'(mem[8'(8'h50 + i)]), 32'(16'hD000 + i));

    // DMA burst interrupted by a CPU read: capped at 4 beats, resumes afterwards.
    c_cmd   = '{MNONE, MREAD, MREAD, MREAD, MREAD, MREAD, MNONE, MNONE};
    c_gnt   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    c_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    c_crv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    c_dreq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    begin
      int beat;
      beat = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        drive(1'b0, c_cmd[c], 8'h50, 16'h0000, c_dreq[c], 1'b1,
              8'(8'h60 + beat), 16'(16'hC000 + beat));
        #1;
        chk($sformatf("cap.c%0d.dma_gnt", c),    32'(bus.dma_gnt),    32'(c_gnt[c]));
        chk($sformatf("cap.c%0d.cpu_stall", c),  32'(bus.cpu_stall),  32'(c_stall[c]));
        chk($sformatf("cap.c%0d.cpu_rvalid", c), 32'(bus.cpu_rvalid), 32'(c_crv[c]));
        if (c_crv[c]) chk($sformatf("cap.c%0d.cpu_rdata", c), 32'(bus.cpu_rdata), 32'hD000);
        if (bus.dma_gnt) beat++;
      end
    end

    // DMA read granted, CPU takes over next cycle: return keeps the DMA tag.
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000);
    #1;
    chk("tag.n.dma_gnt",  32'(bus.dma_gnt),  32'd1);
    chk("tag.n.ram_addr", 32'(bus.ram_addr), 32'h20);
    @(negedge clk); drive(1'b0, MREAD, 8'h30, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("tag.n1.dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    chk("tag.n1.dma_rdata",  32'(bus.dma_rdata),  32'h1234);
    chk("tag.n1.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("tag.n1.cpu_stall",  32'(bus.cpu_stall),  32'd0);
    chk("tag.n1.ram_addr",   32'(bus.ram_addr),   32'h30);
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("tag.n2.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("tag.n2.cpu_rdata",  32'(bus.cpu_rdata),  32'hA5A5);
    chk("tag.n2.dma_rvalid", 32'(bus.dma_rvalid), 32'd0);

    // Reset the cycle after a granted CPU read: the read is dropped.
    @(negedge clk); drive(1'b0, MREAD, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("rst.e0.ram_addr", 32'(bus.ram_addr), 32'h10);
    @(negedge clk); drive(1'b1, MREAD, 8'h10, 16'h0000, 1'b1, 1'b1, 8'h22, 16'h3333);
    #1;
    chk("rst.e1.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst.e1.dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("rst.e1.cpu_stall",  32'(bus.cpu_stall),  32'd0);
    chk("rst.e1.dma_gnt",    32'(bus.dma_gnt),    32'd0);
    chk("rst.e1.ram_we",     32'(bus.ram_we),     32'd0);
    chk("rst.e1.ram_addr",   32'(bus.ram_addr),   32'h00);
    chk("rst.e1.ram_wdata",  32'(bus.ram_wdata),  32'h0000);
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    #1;
    chk("rst.e2.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst.e2.dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    chk("rst.e2.state",      32'(dut.state),      32'(S_IDLE));
    @(negedge clk); drive(1'b0, MREAD, 8'h10, 16'h0000, 1'b1, 1'b1, 8'h22, 16'h3333);
    #1;
    chk("rst.e3.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst.e3.dma_gnt",    32'(bus.dma_gnt),    32'd0);
    chk("rst.e3.cpu_stall",  32'(bus.cpu_stall),  32'd0);
    @(negedge clk); drive(1'b0, MNONE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
